// File: rtl/fp_mul16_rr_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP16 multiplier among NUM_REQ requesters.
// Latency: grant edge to FIFO write is MUL_LAT edges; the result is visible at the FIFO head right after that write.
// Backpressure: rsp_ready stalls the result FIFO; credits (outstanding < FIFO_DEPTH) then stop new grants.
// Optional build macro FP_MUL_ARB_STATS_EN adds per-requester grant counters and a stats_clr input.
module fp_mul16_rr_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  MUL_LAT    = 6,
  parameter int  FIFO_DEPTH = 4,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef FP_MUL_ARB_STATS_EN
  input  logic                   stats_clr,
  output logic [32*NUM_REQ-1:0]  grant_cnt,
`endif
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [15:0]            mul_a,
  output logic [15:0]            mul_b,
  input  logic [15:0]            mul_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [MUL_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0]     tag_id_q [MUL_LAT];
  logic [IDW-1:0]     tag_id_d [MUL_LAT];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]      credit_q, credit_d;
  logic [15:0]        mem_dat_q [FIFO_DEPTH];
  logic [15:0]        mem_dat_d [FIFO_DEPTH];
  logic [IDW-1:0]     mem_id_q [FIFO_DEPTH];
  logic [IDW-1:0]     mem_id_d [FIFO_DEPTH];

  logic               credit_ok, grant_any, wr_en, pop, fifo_full;
  logic [IDW-1:0]     grant_idx;
  int                 cand;

  // Grant search from the RR pointer upward with wrap; reset forces no grant.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    credit_ok = rst && (credit_q < CW'(FIFO_DEPTH));
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_any && credit_ok && req_valid[IDW'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(cand);
      end
    end
    req_ready = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    mul_a     = grant_any ? req_a[16*grant_idx +: 16] : 16'h0000;
    mul_b     = grant_any ? req_b[16*grant_idx +: 16] : 16'h0000;
  end

  assign rsp_valid = (fifo_cnt_q != '0);
  assign rsp_data  = rsp_valid ? mem_dat_q[rd_ptr_q] : 16'h0000;
  assign rsp_id    = rsp_valid ? mem_id_q[rd_ptr_q] : '0;
  assign busy      = (|tag_vld_q) | rsp_valid;
  assign pop       = rsp_valid & rsp_ready;
  assign wr_en     = tag_vld_q[MUL_LAT-1];
  assign fifo_full = (fifo_cnt_q == CW'(FIFO_DEPTH));

  // Next-state for pointer, tag pipe, FIFO and credit counter.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);

    tag_vld_d = {tag_vld_q[MUL_LAT-2:0], grant_any};
    tag_id_d[0] = grant_idx;
    for (int i = 1; i < MUL_LAT; i++) tag_id_d[i] = tag_id_q[i-1];

    mem_dat_d = mem_dat_q;
    mem_id_d  = mem_id_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (wr_en) begin
      mem_dat_d[wr_ptr_q] = mul_out;
      mem_id_d[wr_ptr_q]  = tag_id_q[MUL_LAT-1];
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    fifo_cnt_d = fifo_cnt_q;
    if (wr_en && !pop)      fifo_cnt_d = fifo_cnt_q + CW'(1);
    else if (!wr_en && pop) fifo_cnt_d = fifo_cnt_q - CW'(1);

    credit_d = credit_q;
    if (grant_any && !pop)      credit_d = credit_q + CW'(1);
    else if (!grant_any && pop) credit_d = credit_q - CW'(1);
  end

  // State registers; reset invalidates every tag so stale multiplier output is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q   <= '0;
      tag_vld_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      credit_q   <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_id_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_dat_q[i] <= '0;
        mem_id_q[i]  <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      credit_q   <= credit_d;
      mem_dat_q  <= mem_dat_d;
      mem_id_q   <= mem_id_d;
    end
  end

  // The multiplier cannot stall, so a write into a full FIFO would silently lose a product.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(wr_en && fifo_full && !pop));

`ifdef FP_MUL_ARB_STATS_EN
  logic [32*NUM_REQ-1:0] grant_cnt_q, grant_cnt_d;

  // Per-requester grant counters; clear wins over a same-cycle grant.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (stats_clr) grant_cnt_d = '0;
    else if (grant_any) grant_cnt_d[32*grant_idx +: 32] = grant_cnt_q[32*grant_idx +: 32] + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) grant_cnt_q <= '0;
    else      grant_cnt_q <= grant_cnt_d;
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_fp_mul16_rr_arbiter.sv
// Directed bench for fp_mul16_rr_arbiter: a depth-4 and a depth-8 instance share stimulus.
// The bench plays the 6-cycle multiplier for each instance using a small table of known FP16 products.
// Monitors log every popped response so ordering can be checked after a stream.
module tb_fp_mul16_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic        rsp_ready = 1'b0;
  logic        stats_clr = 1'b0;

  logic [3:0]  req_ready4, req_ready8;
  logic [15:0] mul_a4, mul_b4, mul_out4, rsp_data4;
  logic [15:0] mul_a8, mul_b8, mul_out8, rsp_data8;
  logic        rsp_valid4, rsp_valid8, busy4, busy8;
  logic [1:0]  rsp_id4, rsp_id8;
`ifdef FP_MUL_ARB_STATS_EN
  logic [127:0] grant_cnt4, grant_cnt8;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mp4 [6];
  logic [15:0] mp8 [6];
  logic [17:0] q4 [$];
  logic [17:0] q8 [$];

  always #5 clk = ~clk;

  fp_mul16_rr_arbiter #(.NUM_REQ(4), .MUL_LAT(6), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
`ifdef FP_MUL_ARB_STATS_EN
    .stats_clr(stats_clr), .grant_cnt(grant_cnt4),
`endif
    .req_valid(req_valid), .req_ready(req_ready4), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a4), .mul_b(mul_b4), .mul_out(mul_out4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_data(rsp_data4), .rsp_id(rsp_id4),
    .busy(busy4)
  );

  fp_mul16_rr_arbiter #(.NUM_REQ(4), .MUL_LAT(6), .FIFO_DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
`ifdef FP_MUL_ARB_STATS_EN
    .stats_clr(stats_clr), .grant_cnt(grant_cnt8),
`endif
    .req_valid(req_valid), .req_ready(req_ready8), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a8), .mul_b(mul_b8), .mul_out(mul_out8),
    .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready), .rsp_data(rsp_data8), .rsp_id(rsp_id8),
    .busy(busy8)
  );

  // Known FP16 products: x*1.0 = x, zero operand -> +0, 2.0*3.0 = 6.0; anything else -> NaN.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    if (a[14:0] == 15'h0 || b[14:0] == 15'h0) return 16'h0000;
    if (a == 16'h3C00) return b;
    if (b == 16'h3C00) return a;
    if (a == 16'h4000 && b == 16'h4200) return 16'h4600;
    return 16'h7E00;
  endfunction

  // Multiplier models: sample at the edge, six register stages; deliberately not reset.
  always @(posedge clk) begin
    mp4[0] <= fmul(mul_a4, mul_b4);
    mp8[0] <= fmul(mul_a8, mul_b8);
    for (int i = 1; i < 6; i++) begin
      mp4[i] <= mp4[i-1];
      mp8[i] <= mp8[i-1];
    end
  end
  assign mul_out4 = mp4[5];
  assign mul_out8 = mp8[5];

  // Log each accepted response (sampled mid-cycle, popped at the next rising edge).
  always @(negedge clk) begin
    if (rst && rsp_valid4 && rsp_ready) q4.push_back({rsp_id4, rsp_data4});
    if (rst && rsp_valid8 && rsp_ready) q8.push_back({rsp_id8, rsp_data8});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic set_lanes_unit_a();
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = 16'h3C00;
      req_b[16*i +: 16] = 16'h4000 + 16'(i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 4'b1111;
    set_lanes_unit_a();
    tick();
    tick();
    vectors++;
    if ({req_ready4, rsp_valid4, busy4, rsp_data4, rsp_id4} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b dat=%h id=%0d want all 0",
               req_ready4, rsp_valid4, busy4, rsp_data4, rsp_id4);
    end
    vectors++;
    if ({mul_a4, mul_b4} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mul_ops: got a=%h b=%h want 0000 0000", mul_a4, mul_b4);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_a = 64'h1111_2222_3333_4000;
    req_b = 64'h5555_6666_7777_4200;
    req_valid = 4'b0001;
    #1;
    vectors++;
    if (req_ready4 !== 4'b0001 || mul_a4 !== 16'h4000 || mul_b4 !== 16'h4200) begin
      miscompares++;
      $display("FAIL single_grant: got rdy=%b a=%h b=%h want 0001 4000 4200", req_ready4, mul_a4, mul_b4);
    end
    tick();
    req_valid = 4'b0000;
    #1;
    vectors++;
    if (busy4 !== 1'b1 || req_ready4 !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_busy: got busy=%b rdy=%b want 1 0000", busy4, req_ready4);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) begin
        vectors++;
        if (rsp_valid4 !== 1'b0) begin
          miscompares++;
          $display("FAIL single_early: got rsp_valid=%b want 0 at edge 5", rsp_valid4);
        end
      end
    end
    vectors++;
    if (rsp_valid4 !== 1'b1 || rsp_data4 !== 16'h4600 || rsp_id4 !== 2'd0) begin
      miscompares++;
      $display("FAIL single_result: got vld=%b dat=%h id=%0d want 1 4600 0", rsp_valid4, rsp_data4, rsp_id4);
    end
    tick();
    vectors++;
    if (busy4 !== 1'b0 || rsp_valid4 !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: got busy=%b vld=%b want 0 0", busy4, rsp_valid4);
    end
  endtask

  task automatic test_zero_and_one();
    bit ok;
    req_a[47:32] = 16'h0000;
    req_b[47:32] = 16'h4500;
    req_a[31:16] = 16'h3C00;
    req_b[31:16] = 16'h3C00;
    req_valid = 4'b0100;
    #1;
    vectors++;
    if (req_ready4 !== 4'b0100 || mul_b4 !== 16'h4500) begin
      miscompares++;
      $display("FAIL zero_grant: got rdy=%b b=%h want 0100 4500", req_ready4, mul_b4);
    end
    tick();
    req_valid = 4'b0010;
    #1;
    vectors++;
    if (req_ready4 !== 4'b0010) begin
      miscompares++;
      $display("FAIL rr_wrap_grant: got rdy=%b want 0010", req_ready4);
    end
    tick();
    req_valid = 4'b0000;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid4) begin ok = 1'b1; break; end
      tick();
    end
    vectors++;
    if (!ok || rsp_data4 !== 16'h0000 || rsp_id4 !== 2'd2) begin
      miscompares++;
      $display("FAIL zero_result: got vld=%b dat=%h id=%0d want 1 0000 2", ok, rsp_data4, rsp_id4);
    end
    tick();
    vectors++;
    if (rsp_valid4 !== 1'b1 || rsp_data4 !== 16'h3C00 || rsp_id4 !== 2'd1) begin
      miscompares++;
      $display("FAIL one_result: got vld=%b dat=%h id=%0d want 1 3c00 1", rsp_valid4, rsp_data4, rsp_id4);
    end
    tick();
  endtask

  task automatic test_rr_stream();
    int base;
    logic [17:0] e;
    do_reset();
    rsp_ready = 1'b1;
    set_lanes_unit_a();
    base = q8.size();
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 10; g++) begin
      vectors++;
      if (req_ready8 !== (4'b0001 << (g % 4))) begin
        miscompares++;
        $display("FAIL stream_grant%0d: got %b want %b", g, req_ready8, 4'b0001 << (g % 4));
      end
      tick();
    end
    req_valid = 4'b0000;
    for (int i = 0; i < 12; i++) tick();
    vectors++;
    if (q8.size() - base != 10) begin
      miscompares++;
      $display("FAIL stream_count: got %0d responses want 10", q8.size() - base);
    end
    for (int g = 0; g < 10 && base + g < q8.size(); g++) begin
      e = q8[base + g];
      vectors++;
      if (e !== {2'(g % 4), 16'h4000 + 16'(g % 4)}) begin
        miscompares++;
        $display("FAIL stream_rsp%0d: got id=%0d dat=%h want id=%0d dat=%h",
                 g, e[17:16], e[15:0], g % 4, 16'h4000 + 16'(g % 4));
      end
    end
`ifdef FP_MUL_ARB_STATS_EN
    vectors++;
    if (grant_cnt8 !== {32'd2, 32'd2, 32'd3, 32'd3}) begin
      miscompares++;
      $display("FAIL stats_count: got %h want 2,2,3,3", grant_cnt8);
    end
    stats_clr = 1'b1;
    req_valid = 4'b0001;
    tick();
    stats_clr = 1'b0;
    req_valid = 4'b0000;
    vectors++;
    if (grant_cnt8 !== 128'h0) begin
      miscompares++;
      $display("FAIL stats_clear: got %h want 0", grant_cnt8);
    end
    for (int i = 0; i < 10; i++) tick();
`endif
  endtask

  task automatic test_backpressure();
    int grants;
    int base;
    logic [17:0] e;
    do_reset();
    rsp_ready = 1'b0;
    set_lanes_unit_a();
    req_valid = 4'b1111;
    #1;
    grants = 0;
    for (int c = 0; c < 12; c++) begin
      if (req_ready4 != 4'b0000) grants++;
      tick();
    end
    vectors++;
    if (grants != 4 || req_ready4 !== 4'b0000 || rsp_valid4 !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_credit: got grants=%0d rdy=%b vld=%b want 4 0000 1", grants, req_ready4, rsp_valid4);
    end
    base = q4.size();
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready4 !== 4'b0000) begin
      miscompares++;
      $display("FAIL bp_pop_same_cycle: got rdy=%b want 0000", req_ready4);
    end
    tick();
    vectors++;
    if (req_ready4 !== 4'b0001) begin
      miscompares++;
      $display("FAIL bp_regrant: got rdy=%b want 0001", req_ready4);
    end
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 14; i++) tick();
    vectors++;
    if (q4.size() - base != 5) begin
      miscompares++;
      $display("FAIL bp_count: got %0d responses want 5", q4.size() - base);
    end
    for (int g = 0; g < 5 && base + g < q4.size(); g++) begin
      e = q4[base + g];
      vectors++;
      if (e !== {2'(g % 4), 16'h4000 + 16'(g % 4)}) begin
        miscompares++;
        $display("FAIL bp_rsp%0d: got id=%0d dat=%h want id=%0d dat=%h",
                 g, e[17:16], e[15:0], g % 4, 16'h4000 + 16'(g % 4));
      end
    end
  endtask

  task automatic test_reset_midflight();
    int stray;
    bit ok;
    do_reset();
    rsp_ready = 1'b1;
    set_lanes_unit_a();
    req_valid = 4'b0001;
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if ({req_ready4, rsp_valid4, busy4, rsp_data4, rsp_id4, mul_a4} !== 40'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got rdy=%b vld=%b busy=%b dat=%h id=%0d a=%h want all 0",
               req_ready4, rsp_valid4, busy4, rsp_data4, rsp_id4, mul_a4);
    end
    tick();
    tick();
    req_valid = 4'b0000;
    rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid4 || busy4) stray++;
      tick();
    end
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL midreset_stale: got %0d cycles with rsp_valid/busy want 0", stray);
    end
    req_a[63:48] = 16'h3C00;
    req_b[63:48] = 16'h4400;
    req_valid = 4'b1000;
    #1;
    vectors++;
    if (req_ready4 !== 4'b1000) begin
      miscompares++;
      $display("FAIL midreset_grant: got rdy=%b want 1000", req_ready4);
    end
    tick();
    req_valid = 4'b0000;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid4) begin ok = 1'b1; break; end
      tick();
    end
    vectors++;
    if (!ok || rsp_data4 !== 16'h4400 || rsp_id4 !== 2'd3) begin
      miscompares++;
      $display("FAIL midreset_result: got vld=%b dat=%h id=%0d want 1 4400 3", ok, rsp_data4, rsp_id4);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_and_one();
    test_rr_stream();
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
